// File: rtl/priv_1_12_counters.sv
`default_nettype none
// ============================================================================
// Module      : priv_1_12_counters
// Description : Machine counter/timer CSR bank (mcycle, minstret,
//               mcountinhibit, mcounteren and the user read-only shadows).
//               Optional macro PRIV_COUNTER_TIME_EN adds time/timeh views.
// Revision    : 1.0 - initial release
// ============================================================================
module priv_1_12_counters #(
    parameter int         CNT_W       = 64,
    parameter logic [2:0] INHIBIT_RST = 3'b000,
    parameter logic [2:0] CNTEN_RST   = 3'b000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  curr_priv,
    input  logic        csr_write,
    input  logic        csr_set,
    input  logic        csr_clear,
    input  logic [31:0] new_csr_val,
    input  logic        inst_ret,
    input  logic [63:0] mtime,
    output logic        csr_hit,
    output logic        invalid_csr,
    output logic [31:0] old_csr_val
);

    localparam logic [11:0] c_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_ADDR_MINHIBIT  = 12'h320;
    localparam logic [11:0] c_ADDR_MCNTEN    = 12'h306;
    localparam logic [11:0] c_ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] c_ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] c_ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] c_ADDR_INSTRETH  = 12'hC82;
`ifdef PRIV_COUNTER_TIME_EN
    localparam logic [11:0] c_ADDR_TIME      = 12'hC01;
    localparam logic [11:0] c_ADDR_TIMEH     = 12'hC81;
`endif

    logic [CNT_W-1:0] r_mcycle;
    logic [CNT_W-1:0] r_minstret;
    logic             r_inh_cy;
    logic             r_inh_ir;
    logic             r_en_cy;
    logic             r_en_ir;
    logic [2:0]       w_cnten;

`ifdef PRIV_COUNTER_TIME_EN
    logic             r_en_tm;
    assign w_cnten = {r_en_ir, r_en_tm, r_en_cy};
`else
    logic             w_unused_mtime;
    assign w_unused_mtime = ^mtime;
    assign w_cnten = {r_en_ir, 1'b0, r_en_cy};
`endif

    logic [31:0] w_cy_hi;
    logic [31:0] w_ir_hi;
    assign w_cy_hi = 32'(r_mcycle[CNT_W-1:32]);
    assign w_ir_hi = 32'(r_minstret[CNT_W-1:32]);

    logic        w_hit;
    logic        w_m_addr;
    logic        w_u_addr;
    logic        w_u_en;
    logic [31:0] w_rdata;

    always_comb begin
        w_hit    = 1'b0;
        w_m_addr = 1'b0;
        w_u_addr = 1'b0;
        w_u_en   = 1'b0;
        w_rdata  = 32'h0;
        case (csr_addr)
            c_ADDR_MCYCLE:    begin w_hit = 1'b1; w_m_addr = 1'b1; w_rdata = r_mcycle[31:0];   end
            c_ADDR_MCYCLEH:   begin w_hit = 1'b1; w_m_addr = 1'b1; w_rdata = w_cy_hi;          end
            c_ADDR_MINSTRET:  begin w_hit = 1'b1; w_m_addr = 1'b1; w_rdata = r_minstret[31:0]; end
            c_ADDR_MINSTRETH: begin w_hit = 1'b1; w_m_addr = 1'b1; w_rdata = w_ir_hi;          end
            c_ADDR_MINHIBIT:  begin w_hit = 1'b1; w_m_addr = 1'b1;
                                    w_rdata = {29'h0, r_inh_ir, 1'b0, r_inh_cy};               end
            c_ADDR_MCNTEN:    begin w_hit = 1'b1; w_m_addr = 1'b1; w_rdata = {29'h0, w_cnten}; end
            c_ADDR_CYCLE:     begin w_hit = 1'b1; w_u_addr = 1'b1; w_u_en = w_cnten[0];
                                    w_rdata = r_mcycle[31:0];                                  end
            c_ADDR_CYCLEH:    begin w_hit = 1'b1; w_u_addr = 1'b1; w_u_en = w_cnten[0];
                                    w_rdata = w_cy_hi;                                         end
            c_ADDR_INSTRET:   begin w_hit = 1'b1; w_u_addr = 1'b1; w_u_en = w_cnten[2];
                                    w_rdata = r_minstret[31:0];                                end
            c_ADDR_INSTRETH:  begin w_hit = 1'b1; w_u_addr = 1'b1; w_u_en = w_cnten[2];
                                    w_rdata = w_ir_hi;                                         end
`ifdef PRIV_COUNTER_TIME_EN
            c_ADDR_TIME:      begin w_hit = 1'b1; w_u_addr = 1'b1; w_u_en = w_cnten[1];
                                    w_rdata = mtime[31:0];                                     end
            c_ADDR_TIMEH:     begin w_hit = 1'b1; w_u_addr = 1'b1; w_u_en = w_cnten[1];
                                    w_rdata = mtime[63:32];                                    end
`endif
            default: ;
        endcase
    end

    logic        w_mod;
    logic        w_priv_m;
    logic        w_invalid;
    logic        w_we;
    logic [31:0] w_new;

    assign w_mod       = csr_write | csr_set | csr_clear;
    assign w_priv_m    = (curr_priv == 2'b11);
    assign w_invalid   = w_hit & (((w_m_addr | (w_u_addr & ~w_u_en)) & ~w_priv_m) |
                                  (w_u_addr & w_mod));
    // Only M-space addresses ever reach here: user shadows always fail as ro.
    assign w_we        = w_hit & w_mod & ~w_invalid;
    assign w_new       = csr_write ? new_csr_val :
                         csr_set   ? (w_rdata | new_csr_val) :
                                     (w_rdata & ~new_csr_val);

    assign csr_hit     = w_hit;
    assign invalid_csr = w_invalid;
    assign old_csr_val = w_rdata;

    logic [CNT_W-1:0] w_cy_inc;
    logic [CNT_W-1:0] w_ir_inc;
    logic [CNT_W-1:0] w_mcycle_nxt;
    logic [CNT_W-1:0] w_minstret_nxt;

    assign w_cy_inc = r_mcycle   + {{(CNT_W-1){1'b0}}, ~r_inh_cy};
    assign w_ir_inc = r_minstret + {{(CNT_W-1){1'b0}}, inst_ret & ~r_inh_ir};

    // A low-half write drops the increment; a high-half write keeps the low
    // increment but discards its carry.
    always_comb begin
        w_mcycle_nxt   = w_cy_inc;
        w_minstret_nxt = w_ir_inc;
        if (w_we && csr_addr == c_ADDR_MCYCLE)
            w_mcycle_nxt = {r_mcycle[CNT_W-1:32], w_new};
        else if (w_we && csr_addr == c_ADDR_MCYCLEH)
            w_mcycle_nxt = {w_new[CNT_W-33:0], w_cy_inc[31:0]};
        if (w_we && csr_addr == c_ADDR_MINSTRET)
            w_minstret_nxt = {r_minstret[CNT_W-1:32], w_new};
        else if (w_we && csr_addr == c_ADDR_MINSTRETH)
            w_minstret_nxt = {w_new[CNT_W-33:0], w_ir_inc[31:0]};
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
            r_inh_cy   <= INHIBIT_RST[0];
            r_inh_ir   <= INHIBIT_RST[2];
            r_en_cy    <= CNTEN_RST[0];
            r_en_ir    <= CNTEN_RST[2];
`ifdef PRIV_COUNTER_TIME_EN
            r_en_tm    <= CNTEN_RST[1];
`endif
        end else begin
            r_mcycle   <= w_mcycle_nxt;
            r_minstret <= w_minstret_nxt;
            if (w_we && csr_addr == c_ADDR_MINHIBIT) begin
                r_inh_cy <= w_new[0];
                r_inh_ir <= w_new[2];
            end
            if (w_we && csr_addr == c_ADDR_MCNTEN) begin
                r_en_cy <= w_new[0];
                r_en_ir <= w_new[2];
`ifdef PRIV_COUNTER_TIME_EN
                r_en_tm <= w_new[1];
`endif
            end
        end
    end

endmodule
`default_nettype wire
